// File: rtl/elevator_call_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// elevator_call_ctrl_pkg
// Shared encodings for the elevator call controller and its neighbours.
//   - FSM state codes (IDLE, CLOSING, MOVING, ARRIVED)
//   - travel direction codes (UP, DOWN)
//   - door status codes (OPEN, CLOSED), identical to those of the door FSM
// -----------------------------------------------------------------------------
package elevator_call_ctrl_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CLOSING = 2'd1;
   localparam logic [1:0] MOVING  = 2'd2;
   localparam logic [1:0] ARRIVED = 2'd3;

   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;

   localparam logic OPEN   = 1'b0;
   localparam logic CLOSED = 1'b1;

endpackage

// File: rtl/elevator_call_ctrl_if.sv
// -----------------------------------------------------------------------------
// elevator_call_ctrl_if
// Bundles the controller's floor/door/motor signals.
//   btn        : floor-call buttons, level, one bit per floor
//   alarm      : emergency alarm, 1 = freeze motion
//   door       : door status from the door FSM (1 = closed, 0 = open)
//   calls      : request to the door FSM to close and stay closed
//   motor_up   : car is moving up
//   motor_down : car is moving down
//   floor      : current floor index
//   pending    : registered request vector
// Modports: master = the controller, slave = its environment.
// -----------------------------------------------------------------------------
interface elevator_call_ctrl_if #(
   parameter int N_FLOORS = 4,
   parameter int FLOOR_W  = 2
);
   logic [N_FLOORS-1:0] btn;
   logic                alarm;
   logic                door;
   logic                calls;
   logic                motor_up;
   logic                motor_down;
   logic [FLOOR_W-1:0]  floor;
   logic [N_FLOORS-1:0] pending;

   modport master (
      input  btn, alarm, door,
      output calls, motor_up, motor_down, floor, pending
   );

   modport slave (
      output btn, alarm, door,
      input  calls, motor_up, motor_down, floor, pending
   );
endinterface

// File: rtl/elevator_call_ctrl_call_dir_resolver.sv
// -----------------------------------------------------------------------------
// elevator_call_ctrl_call_dir_resolver
// Combinational helper: tells whether any request lies ahead of the car in
// its current direction, or behind it. The current floor itself counts as
// neither.
//   pending    : request vector
//   floor      : current floor index
//   dir        : current direction (UP / DOWN)
//   req_ahead  : some request strictly beyond floor in dir
//   req_behind : some request strictly beyond floor against dir
// -----------------------------------------------------------------------------
module elevator_call_ctrl_call_dir_resolver
   import elevator_call_ctrl_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int FLOOR_W  = 2
) (
   input  logic [N_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]  floor,
   input  logic                dir,
   output logic                req_ahead,
   output logic                req_behind
);

   logic req_above;
   logic req_below;

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      req_above = 1'b0;
      req_below = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (pending[i] && (i > int'(floor))) req_above = 1'b1;
         if (pending[i] && (i < int'(floor))) req_below = 1'b1;
      end
   end

   assign req_ahead  = (dir == UP) ? req_above : req_below;
   assign req_behind = (dir == UP) ? req_below : req_above;

endmodule

// File: rtl/elevator_call_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_call_ctrl
// Registers floor calls, schedules travel with a SCAN (keep-direction) policy
// and models car motion with a per-floor travel timer. Sits upstream of the
// door FSM: drives its `calls` input and reads back its `door` output.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : btn/alarm/door in, calls/motor_up/motor_down/floor/pending out
// -----------------------------------------------------------------------------
module elevator_call_ctrl
   import elevator_call_ctrl_pkg::*;
#(
   parameter int N_FLOORS      = 4,
   parameter int FLOOR_W       = 2,
   parameter int TRAVEL_CYCLES = 50,
   parameter int DWELL_CYCLES  = 100,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   elevator_call_ctrl_if.master bus
);

   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);
   localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);

   logic [1:0]          state_q,      state_d;
   logic [FLOOR_W-1:0]  floor_q,      floor_d;
   logic [N_FLOORS-1:0] pending_q,    pending_d;
   logic                dir_q,        dir_d;
   logic [CNT_W-1:0]    timer_q,      timer_d;
   logic                resume_q,     resume_d;   // re-close after a door fault
   logic                calls_q,      calls_d;
   logic                motor_up_q,   motor_up_d;
   logic                motor_down_q, motor_down_d;

   logic [N_FLOORS-1:0] clr;
   logic                dir_bound;
   logic [FLOOR_W-1:0]  step_floor;
   logic                req_ahead;
   logic                req_behind;

   function automatic logic [N_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
      floor_bit    = '0;
      floor_bit[f] = 1'b1;
   endfunction

   elevator_call_ctrl_call_dir_resolver #(
      .N_FLOORS (N_FLOORS),
      .FLOOR_W  (FLOOR_W)
   ) call_dir_resolver (
      .pending    (pending_q),
      .floor      (floor_q),
      .dir        (dir_q),
      .req_ahead  (req_ahead),
      .req_behind (req_behind)
   );

   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      dir_d    = dir_q;
      timer_d  = timer_q;
      resume_d = resume_q;
      clr      = '0;

      // The end floors only allow one way out.
      if (floor_q == TOP_FLOOR)  dir_bound = DOWN;
      else if (floor_q == '0)    dir_bound = UP;
      else                       dir_bound = dir_q;
      step_floor = (dir_bound == UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

      if (bus.alarm) begin
         // Motion frozen; a call at the parked floor is still served at once.
         if (state_q == IDLE) clr = floor_bit(floor_q);
      end else begin
         case (state_q)
            IDLE: begin
               clr = floor_bit(floor_q);
               if ((pending_q & ~clr) != '0) begin
                  dir_d   = req_ahead ? dir_q : ~dir_q;
                  state_d = CLOSING;
               end
            end
            CLOSING: begin
               if (bus.door == CLOSED) begin
                  state_d  = MOVING;
                  dir_d    = dir_bound;
                  resume_d = 1'b0;
                  // After a door fault the partial trip is kept.
                  if (!resume_q) timer_d = '0;
               end
            end
            MOVING: begin
               if (bus.door == OPEN) begin
                  state_d  = CLOSING;
                  resume_d = 1'b1;
               end else if (timer_q == TRAVEL_LAST) begin
                  floor_d = step_floor;
                  timer_d = '0;
                  if (pending_q[step_floor]) begin
                     state_d = ARRIVED;
                     clr     = floor_bit(step_floor);
                  end
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            ARRIVED: begin
               if (timer_q == DWELL_LAST) begin
                  timer_d = '0;
                  if (req_ahead) begin
                     state_d = CLOSING;
                  end else if (req_behind) begin
                     dir_d   = ~dir_q;
                     state_d = CLOSING;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Clear wins over a simultaneous press.
      pending_d = (pending_q | bus.btn) & ~clr;

      // Outputs follow the next state so they land on the same edge as it.
      calls_d      = bus.alarm ? calls_q : ((state_d == CLOSING) || (state_d == MOVING));
      motor_up_d   = !bus.alarm && (state_d == MOVING) && (dir_d == UP);
      motor_down_d = !bus.alarm && (state_d == MOVING) && (dir_d == DOWN);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         floor_q      <= '0;
         pending_q    <= '0;
         dir_q        <= UP;
         timer_q      <= '0;
         resume_q     <= 1'b0;
         calls_q      <= 1'b0;
         motor_up_q   <= 1'b0;
         motor_down_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         floor_q      <= floor_d;
         pending_q    <= pending_d;
         dir_q        <= dir_d;
         timer_q      <= timer_d;
         resume_q     <= resume_d;
         calls_q      <= calls_d;
         motor_up_q   <= motor_up_d;
         motor_down_q <= motor_down_d;
      end
   end

   assign bus.calls      = calls_q;
   assign bus.motor_up   = motor_up_q;
   assign bus.motor_down = motor_down_q;
   assign bus.floor      = floor_q;
   assign bus.pending    = pending_q;

endmodule
